// File: rtl/jno_sequencer_pkg.sv
// Shared definitions for the jno_sequencer instruction sequencer.
// Holds the 2-bit opcode encoding and the FSM state encoding.
// No logic here; imported by the sequencer and its bench.
package jno_sequencer_pkg;

  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_JNO = 2'b01;
  localparam logic [1:0] OP_HLT = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_OPER  = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

endpackage

// File: rtl/jno_sequencer.sv
// Purpose: fetch/decode/execute sequencer for the INC / JNO / HLT / NOP program memory.
// Latency: INC, NOP and HLT take 2 cycles, JNO takes 3; busy rises on the edge after start.
// Backpressure: none; the memory reads combinationally and start is ignored while busy.
//
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset
//   start           - begin a run at address 0 (only honoured in IDLE or HALT)
//   imem_addr       - program memory address (the PC register)
//   imem_data       - program memory word for imem_addr, same cycle
//   busy / halted   - registered status flags
//   acc / ovf       - accumulator and overflow flag
module jno_sequencer
  import jno_sequencer_pkg::*;
#(
  parameter int AW   = 2,
  parameter int DW   = 2,
  parameter int ACCW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [AW-1:0]   imem_addr,
  input  logic [DW-1:0]   imem_data,
  output logic            busy,
  output logic            halted,
  output logic [ACCW-1:0] acc,
  output logic            ovf
);

  state_t          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [1:0]      ir_q, ir_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic            halted_q, halted_d;

  // One extra bit so the carry-out of the increment lands in the MSB.
  logic [ACCW:0]   acc_inc;
  logic [AW-1:0]   pc_inc;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    acc_inc  = {1'b0, acc_q} + {{ACCW{1'b0}}, 1'b1};
    pc_inc   = pc_q + {{(AW-1){1'b0}}, 1'b1};

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_FETCH: begin
        ir_d    = imem_data[1:0];
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (ir_q)
          OP_INC: begin
            acc_d   = acc_inc[ACCW-1:0];
            ovf_d   = acc_inc[ACCW];
            pc_d    = pc_inc;
            state_d = ST_FETCH;
          end
          OP_JNO: begin
            // Step onto the operand word; it is sampled in OPER.
            pc_d    = pc_inc;
            state_d = ST_OPER;
          end
          OP_HLT: begin
            state_d = ST_HALT;
          end
          default: begin
            pc_d    = pc_inc;
            state_d = ST_FETCH;
          end
        endcase
      end
      ST_OPER: begin
        pc_d    = ovf_q ? pc_inc : imem_data[AW-1:0];
        state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase

    // Status flags are registered from the next state so they stay glitch-free.
    busy_d   = (state_d == ST_FETCH) || (state_d == ST_EXEC) || (state_d == ST_OPER);
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      ir_q     <= OP_INC;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  assign imem_addr = pc_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign acc       = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_jno_sequencer.sv
// Bench for jno_sequencer with AW = DW = ACCW = 2 and a combinational program memory.
// An instruction-level model pushes the expected per-edge trace; the DUT is compared each edge.
// No backpressure; all waits are fixed edge counts.
module tb_jno_sequencer;
  import jno_sequencer_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] imem_addr;
  logic [1:0] imem_data;
  logic       busy;
  logic       halted;
  logic [1:0] acc;
  logic       ovf;

  logic [1:0] mem [4];

  int n_checks;
  int n_errors;

  typedef struct packed {
    logic [1:0] addr;
    logic       busy;
    logic       halted;
    logic [1:0] acc;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];

  jno_sequencer #(.AW(2), .DW(2), .ACCW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .busy      (busy),
    .halted    (halted),
    .acc       (acc),
    .ovf       (ovf)
  );

  assign imem_data = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Instruction-level reference: one entry per clock edge, starting with the start-sampling edge.
  logic [1:0] m_pc, m_acc;
  logic       m_ovf, m_halted;
  int         m_cnt, m_lim;

  task automatic m_push(input logic b);
    exp_t e;
    if (m_cnt < m_lim) begin
      e.addr   = m_pc;
      e.busy   = b;
      e.halted = m_halted;
      e.acc    = m_acc;
      e.ovf    = m_ovf;
      exp_q.push_back(e);
      m_cnt++;
    end
  endtask

  task automatic model_run(input int n);
    logic [1:0] op;
    logic [2:0] sum;
    m_lim = n; m_cnt = 0;
    m_pc = 2'd0; m_acc = 2'd0; m_ovf = 1'b0; m_halted = 1'b0;
    m_push(1'b1);
    while (m_cnt < m_lim) begin
      if (m_halted) begin
        m_push(1'b0);
      end else begin
        op = mem[m_pc];
        m_push(1'b1);                       // fetch edge
        case (op)
          OP_INC: begin
            sum = {1'b0, m_acc} + 3'd1;
            m_acc = sum[1:0]; m_ovf = sum[2]; m_pc = m_pc + 2'd1;
            m_push(1'b1);
          end
          OP_JNO: begin
            m_pc = m_pc + 2'd1;
            m_push(1'b1);
            m_pc = m_ovf ? m_pc + 2'd1 : mem[m_pc];
            m_push(1'b1);
          end
          OP_HLT: begin
            m_halted = 1'b1;
            m_push(1'b0);
          end
          default: begin
            m_pc = m_pc + 2'd1;
            m_push(1'b1);
          end
        endcase
      end
    end
  endtask

  task automatic tick_check(input string tag);
    exp_t e;
    @(posedge clk); #1;
    if (exp_q.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, " addr"},   32'(imem_addr), 32'(e.addr));
      chk({tag, " busy"},   32'(busy),      32'(e.busy));
      chk({tag, " halted"}, 32'(halted),    32'(e.halted));
      chk({tag, " acc"},    32'(acc),       32'(e.acc));
      chk({tag, " ovf"},    32'(ovf),       32'(e.ovf));
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " addr"},   32'(imem_addr), 32'd0);
    chk({tag, " busy"},   32'(busy),      32'd0);
    chk({tag, " halted"}, 32'(halted),    32'd0);
    chk({tag, " acc"},    32'(acc),       32'd0);
    chk({tag, " ovf"},    32'(ovf),       32'd0);
  endtask

  // Runs n edges from a start pulse (or start held until halt). Edge 0 samples start.
  task automatic run_prog(input string tag, input int n, input bit hold, output int first_h);
    exp_q.delete();
    model_run(n);
    first_h = -1;
    @(negedge clk); start = 1'b1;
    for (int e = 0; e < n; e++) begin
      tick_check($sformatf("%s e%0d", tag, e));
      if (halted && first_h < 0) begin
        first_h = e;
        chk({tag, " halt_acc"},  32'(acc),       32'd0);
        chk({tag, " halt_ovf"},  32'(ovf),       32'd1);
        chk({tag, " halt_addr"}, 32'(imem_addr), 32'd3);
      end
      @(negedge clk); start = hold && (first_h < 0);
    end
    start = 1'b0;
  endtask

  int fh;

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; start = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = 2'($urandom);

    // Reset with random inputs for two edges.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      for (int j = 0; j < 4; j++) mem[j] = 2'($urandom);
      @(posedge clk); #1;
      check_idle($sformatf("reset e%0d", i));
    end
    @(negedge clk); rst_n = 1'b1; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_idle($sformatf("idle e%0d", i));
    end

    // Reference loop: INC, JNO, 00, HLT.
    mem[0] = OP_INC; mem[1] = OP_JNO; mem[2] = 2'b00; mem[3] = OP_HLT;
    run_prog("ref", 25, 1'b0, fh);
    chk("ref halt_edge", 32'(fh), 32'd22);

    // Same program with start held high while busy.
    run_prog("hold", 25, 1'b1, fh);
    chk("hold halt_edge", 32'(fh), 32'd22);

    // Restart from HALT with acc = 0 and ovf = 1 left over.
    chk("restart pre_halted", 32'(halted), 32'd1);
    chk("restart pre_ovf",    32'(ovf),    32'd1);
    run_prog("restart", 25, 1'b0, fh);
    chk("restart halt_edge", 32'(fh), 32'd22);

    // Wrap and NOP: operand fetch wraps to address 0, the jump is taken every time.
    mem[0] = OP_NOP; mem[1] = OP_NOP; mem[2] = OP_NOP; mem[3] = OP_JNO;
    run_prog("wrap", 40, 1'b0, fh);
    chk("wrap never_halts", 32'(fh), 32'hFFFF_FFFF);
    chk("wrap busy_end",    32'(busy), 32'd1);
    chk("wrap acc_end",     32'(acc),  32'd0);

    // Reset during OPER of a JNO whose target (2) differs from the reset pc.
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1;
    mem[0] = OP_INC; mem[1] = OP_JNO; mem[2] = 2'b10; mem[3] = OP_HLT;
    exp_q.delete();
    model_run(5);
    @(negedge clk); start = 1'b1;
    for (int e = 0; e < 5; e++) begin
      tick_check($sformatf("midoper e%0d", e));
      @(negedge clk); start = 1'b0;
    end
    chk("midoper in_oper_addr", 32'(imem_addr), 32'd2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_idle("midoper reset_edge");
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_idle($sformatf("midoper after e%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
